byte_ptr_unit: RTL and testbench

- Multi-cycle byte-pointer engine for the KS-10 datapath.
- Executes IBP, LDB, ILDB and DPB on PDP-10 byte pointers. It writes P/Y fields back into the pointer word and extracts or inserts bytes in the memory word.
- It is the write-back counterpart of the step-count adder, which only reads P/S fields out of the datapath.
- A bit-serial step counter performs the shifts, so latency depends on P.

---
 rtl/byte_ptr_unit.sv | 210 +++++++++++++++++++++
 tb/tb_byte_ptr_unit.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_ptr_unit.sv
// -----------------------------------------------------------------------------
// byte_ptr_unit
//
// Multi-cycle byte-pointer engine for the KS-10 datapath. Executes IBP, LDB,
// ILDB and DPB on PDP-10 byte pointers: advances the P/Y fields of the
// pointer word and extracts a byte from, or deposits a byte into, a memory
// word. Bit numbering follows the PDP-10: bit 0 is the MSB, bit 35 the LSB.
// "Shift right" moves bits toward bit 35.
//
// Configuration macro:
//   BYTEPTR_FASTSHIFT_EN  defined   : SHIFT is one cycle (barrel shifter by Peff)
//                         undefined : bit-serial shift, one bit per cycle
//
// Ports:
//   clk       in   clock
//   rst       in   synchronous active-high reset
//   clken     in   clock enable, gates every state change
//   start     in   op request, sampled only in IDLE
//   op        in   [0:1]  00=IBP 01=LDB 10=DPB 11=ILDB
//   ptr       in   [0:35] byte pointer, P=[0:5] S=[6:11] Y=[18:35]
//   word      in   [0:35] memory word
//   byte_in   in   [0:35] right-justified byte to deposit
//   busy      out  high in every state except IDLE
//   done      out  high while in DONE (one enabled cycle)
//   ptr_out   out  [0:35] updated pointer
//   byte_out  out  [0:35] right-justified extracted byte
//   word_out  out  [0:35] word after deposit
// -----------------------------------------------------------------------------
module byte_ptr_unit #(
   parameter int WIDTH = 36,   // fixed datapath width; do not override
   parameter int CNTW  = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clken,
   input  logic             start,
   input  logic [0:1]       op,
   input  logic [0:WIDTH-1] ptr,
   input  logic [0:WIDTH-1] word,
   input  logic [0:WIDTH-1] byte_in,
   output logic             busy,
   output logic             done,
   output logic [0:WIDTH-1] ptr_out,
   output logic [0:WIDTH-1] byte_out,
   output logic [0:WIDTH-1] word_out
);

   typedef enum logic [2:0] {
      S_IDLE, S_INCR, S_SHIFT, S_MASK, S_DONE
   } state_t;

   typedef enum logic [1:0] {
      OP_IBP  = 2'b00,
      OP_LDB  = 2'b01,
      OP_DPB  = 2'b10,
      OP_ILDB = 2'b11
   } op_t;

   state_t           state, state_nxt;
   op_t              op_r;
   logic [0:WIDTH-1] ptr_r;    // working pointer (P/Y advanced by INCR)
   logic [0:WIDTH-1] word_r;   // original memory word, needed by DPB merge
   logic [0:WIDTH-1] sh_r;     // word (LDB/ILDB) or byte (DPB) being shifted
   logic [0:WIDTH-1] msk_r;    // byte mask, shifted into place for DPB
`ifndef BYTEPTR_FASTSHIFT_EN
   logic [CNTW-1:0]  cnt_r;
`endif

   // P or S clamped to 36: a position or size past the word edge behaves as
   // the word edge, which makes out-of-range fields shift everything out.
   function automatic logic [CNTW-1:0] eff(input logic [5:0] f);
      return (f > 6'd36) ? CNTW'(36) : CNTW'(f);
   endfunction

   // Low Seff bits set; a shift by 36 empties the all-ones vector, so S>=36
   // yields a full-width mask and S=0 an empty one.
   function automatic logic [0:WIDTH-1] low_mask(input logic [5:0] s);
      return ~({WIDTH{1'b1}} << eff(s));
   endfunction

   // Pointer increment. P and S are used raw here; 36-S is a 6-bit result,
   // so S>36 wraps P' to a large value that later clamps to 36.
   logic [5:0]       p_cur, s_cur, p_inc;
   logic [17:0]      y_inc;
   logic [0:WIDTH-1] ptr_inc;

   always_comb begin
      p_cur = ptr_r[0:5];
      s_cur = ptr_r[6:11];
      p_inc = p_cur - s_cur;
      y_inc = ptr_r[18:35];
      if (p_cur < s_cur) begin
         p_inc = 6'd36 - s_cur;
         y_inc = ptr_r[18:35] + 18'd1;
      end
      ptr_inc = {p_inc, ptr_r[6:17], y_inc};
   end

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst)
         state <= S_IDLE;
      else if (clken)
         state <= state_nxt;
   end

   // Next-state logic.
   // NOTE: state_nxt gets a default before the case so no path leaves it
   // unassigned, which would infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:
            if (start)
               state_nxt = (op_t'(op) == OP_IBP || op_t'(op) == OP_ILDB)
                           ? S_INCR : S_SHIFT;
         S_INCR:
            state_nxt = (op_r == OP_ILDB) ? S_SHIFT : S_DONE;
         S_SHIFT: begin
`ifdef BYTEPTR_FASTSHIFT_EN
            state_nxt = S_MASK;
`else
            if (cnt_r == '0)
               state_nxt = S_MASK;
`endif
         end
         S_MASK:
            state_nxt = S_DONE;
         S_DONE:
            state_nxt = S_IDLE;
         default:
            state_nxt = S_IDLE;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_r     <= OP_IBP;
         ptr_r    <= '0;
         word_r   <= '0;
         sh_r     <= '0;
         msk_r    <= '0;
`ifndef BYTEPTR_FASTSHIFT_EN
         cnt_r    <= '0;
`endif
         ptr_out  <= '0;
         byte_out <= '0;
         word_out <= '0;
      end else if (clken) begin
         unique case (state)
            S_IDLE:
               if (start) begin
                  op_r   <= op_t'(op);
                  ptr_r  <= ptr;
                  word_r <= word;
                  sh_r   <= (op_t'(op) == OP_DPB) ? byte_in : word;
                  msk_r  <= low_mask(ptr[6:11]);
`ifndef BYTEPTR_FASTSHIFT_EN
                  cnt_r  <= eff(ptr[0:5]);
`endif
               end
            S_INCR: begin
               ptr_r   <= ptr_inc;
               ptr_out <= ptr_inc;
`ifndef BYTEPTR_FASTSHIFT_EN
               // ILDB shifts by the advanced position P'.
               cnt_r   <= eff(p_inc);
`endif
            end
            S_SHIFT: begin
`ifdef BYTEPTR_FASTSHIFT_EN
               if (op_r == OP_DPB) begin
                  sh_r  <= sh_r  << eff(ptr_r[0:5]);
                  msk_r <= msk_r << eff(ptr_r[0:5]);
               end else begin
                  sh_r  <= sh_r >> eff(ptr_r[0:5]);
               end
`else
               if (cnt_r != '0) begin
                  cnt_r <= cnt_r - 1'b1;
                  if (op_r == OP_DPB) begin
                     sh_r  <= sh_r  << 1;
                     msk_r <= msk_r << 1;
                  end else begin
                     sh_r  <= sh_r >> 1;
                  end
               end
`endif
            end
            S_MASK: begin
               if (op_r == OP_DPB)
                  word_out <= (word_r & ~msk_r) | (sh_r & msk_r);
               else
                  byte_out <= sh_r & msk_r;
               // LDB/DPB leave the pointer as given; IBP/ILDB already wrote it.
               if (op_r == OP_LDB || op_r == OP_DPB)
                  ptr_out <= ptr_r;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != S_IDLE);
   assign done = (state == S_DONE);

endmodule

// File: tb/tb_byte_ptr_unit.sv
// -----------------------------------------------------------------------------
// tb_byte_ptr_unit
//
// Self-checking bench for byte_ptr_unit. Expected pointer, byte, word and
// latency come from an arithmetic model of the byte-pointer rules; directed
// steps also compare against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_byte_ptr_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        clken;
   logic        start;
   logic [1:0]  op_i;
   logic [35:0] ptr_i, word_i, byte_i;
   logic        busy, done;
   logic [35:0] ptr_out, byte_out, word_out;

   int n_cmp = 0;
   int n_bad = 0;

   logic [35:0] exp_ptr, exp_byte, exp_word;
   int          exp_lat;
   int          last_lat;

   localparam logic [1:0] IBP = 2'b00, LDB = 2'b01, DPB = 2'b10, ILDB = 2'b11;

   byte_ptr_unit dut (
      .clk      (clk),
      .rst      (rst),
      .clken    (clken),
      .start    (start),
      .op       (op_i),
      .ptr      (ptr_i),
      .word     (word_i),
      .byte_in  (byte_i),
      .busy     (busy),
      .done     (done),
      .ptr_out  (ptr_out),
      .byte_out (byte_out),
      .word_out (word_out)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0o, expected %0o", tag, obs, exp);
      end
   endtask

   function automatic logic [35:0] rnd36();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[35:0];
   endfunction

   // Pointer increment from the byte-pointer rules, on numeric bit weights.
   function automatic logic [35:0] incr(input logic [35:0] v);
      int pp, ss, yy;
      pp = int'(v[35:30]);
      ss = int'(v[29:24]);
      yy = int'(v[17:0]);
      if (pp >= ss) pp = pp - ss;
      else begin
         pp = (36 - ss) & 63;
         yy = (yy + 1) & 'h3FFFF;
      end
      return {pp[5:0], v[29:18], yy[17:0]};
   endfunction

   task automatic model(input logic [1:0] o, input logic [35:0] p, w, b);
      logic [35:0] pu;
      logic [63:0] m, mm, full;
      int pe, se;
      full = 64'h0000_000F_FFFF_FFFF;
      pu = (o == IBP || o == ILDB) ? incr(p) : p;
      exp_ptr = pu;
      pe = int'(pu[35:30]); if (pe > 36) pe = 36;
      se = int'(pu[29:24]); if (se > 36) se = 36;
      m  = (64'd1 << se) - 64'd1;
      case (o)
         IBP: exp_lat = 2;
         LDB, ILDB: begin
            m = ({28'd0, w} >> pe) & m;
            exp_byte = m[35:0];
`ifdef BYTEPTR_FASTSHIFT_EN
            exp_lat = (o == LDB) ? 3 : 4;
`else
            exp_lat = (o == LDB) ? pe + 3 : pe + 4;
`endif
         end
         default: begin
            mm = (m << pe) & full;
            m  = ({28'd0, w} & ~mm) | (({28'd0, b} << pe) & mm);
            exp_word = m[35:0];
`ifdef BYTEPTR_FASTSHIFT_EN
            exp_lat = 3;
`else
            exp_lat = pe + 3;
`endif
         end
      endcase
   endtask

   // One operation: request, then random (ignored) requests while busy, then
   // compare latency and all outputs against the model.
   task automatic do_op(input string tag, input logic [1:0] o,
                        input logic [35:0] p, w, b, input int gap);
      int  edges, gap_left;
      bit  seen;
      model(o, p, w, b);
      @(negedge clk);
      op_i = o; ptr_i = p; word_i = w; byte_i = b; start = 1'b1; clken = 1'b1;
      @(posedge clk); #1;
      edges = 1;
      check({tag, "_busy"}, {63'd0, busy}, 64'd1);
      seen = 1'b0;
      gap_left = gap;
      while (!seen && edges < 200) begin
         @(negedge clk);
         start = 1'($urandom_range(0, 1));
         op_i = 2'($urandom_range(0, 3));
         ptr_i = rnd36(); word_i = rnd36(); byte_i = rnd36();
         if (gap_left > 0) begin
            clken = 1'b0;
            gap_left--;
         end else clken = 1'b1;
         @(posedge clk); #1;
         edges++;
         if (done) seen = 1'b1;
      end
      last_lat = edges;
      check({tag, "_lat"}, 64'(edges), 64'(exp_lat + gap));
      check({tag, "_ptr"}, {28'd0, ptr_out}, {28'd0, exp_ptr});
      check({tag, "_byte"}, {28'd0, byte_out}, {28'd0, exp_byte});
      check({tag, "_word"}, {28'd0, word_out}, {28'd0, exp_word});
      @(negedge clk);
      start = 1'b0; clken = 1'b1;
      @(posedge clk); #1;
      check({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
   endtask

   initial begin
      int  done_seen;
      logic [5:0]  rp, rs;
      logic [1:0]  ro;
      rst = 1'b1; clken = 1'b1; start = 1'b0; op_i = '0;
      ptr_i = '0; word_i = '0; byte_i = '0;
      exp_ptr = '0; exp_byte = '0; exp_word = '0; exp_lat = 0; last_lat = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_ptr",  {28'd0, ptr_out}, 64'd0);
      check("rst_byte", {28'd0, byte_out}, 64'd0);
      check("rst_word", {28'd0, word_out}, 64'd0);
      @(negedge clk); rst = 1'b0;

      // IBP cases
      do_op("ibp_wrap", IBP, 36'o000600_000100, 36'd0, 36'd0, 0);
      check("tp_ibp_wrap", {28'd0, ptr_out}, 64'o360600_000101);
      check("tp_ibp_lat", 64'(last_lat), 64'd2);
      do_op("ibp_y1", IBP, 36'o060600_777777, 36'd0, 36'd0, 0);
      check("tp_ibp_y1", {28'd0, ptr_out}, 64'o000600_777777);
      do_op("ibp_y2", IBP, 36'o000600_777777, 36'd0, 36'd0, 0);
      check("tp_ibp_y2", {28'd0, ptr_out}, 64'o360600_000000);

      // LDB cases
      do_op("ldb_p30", LDB, 36'o360600_000000, 36'o123456_701234, 36'd0, 0);
      check("tp_ldb_p30", {28'd0, byte_out}, 64'o12);
`ifdef BYTEPTR_FASTSHIFT_EN
      check("tp_ldb_p30_lat", 64'(last_lat), 64'd3);
`else
      check("tp_ldb_p30_lat", 64'(last_lat), 64'd33);
`endif
      do_op("ldb_p0", LDB, 36'o000600_000000, 36'o123456_701234, 36'd0, 0);
      check("tp_ldb_p0", {28'd0, byte_out}, 64'o34);
      check("tp_ldb_p0_lat", 64'(last_lat), 64'd3);
      do_op("ldb_trunc", LDB, 36'o410600_000000, 36'o777777_777777, 36'd0, 0);
      check("tp_ldb_trunc", {28'd0, byte_out}, 64'o7);
      do_op("ldb_p40", LDB, 36'o500600_000000, 36'o777777_777777, 36'd0, 0);
      check("tp_ldb_peff36", {28'd0, byte_out}, 64'd0);

      // DPB cases
      do_op("dpb_p30", DPB, 36'o360600_000000, 36'd0, 36'o77, 0);
      check("tp_dpb_p30", {28'd0, word_out}, 64'o770000_000000);
      do_op("dpb_p0", DPB, 36'o000600_000000, 36'd0, 36'o77, 0);
      check("tp_dpb_p0", {28'd0, word_out}, 64'o000000_000077);
      do_op("dpb_s0", DPB, 36'o360000_000000, 36'd0, 36'o77, 0);
      check("tp_dpb_s0", {28'd0, word_out}, 64'd0);
      do_op("dpb_trunc", DPB, 36'o410600_000000, 36'd0, 36'o77, 0);
      check("tp_dpb_trunc", {28'd0, word_out}, 64'o700000_000000);
      do_op("dpb_p36", DPB, 36'o440600_000000, 36'o123456_701234, 36'o77, 0);
      check("tp_dpb_peff36", {28'd0, word_out}, 64'o123456_701234);

      // ILDB
      do_op("ildb", ILDB, 36'o000600_000005, 36'o112233_445566, 36'd0, 0);
      check("tp_ildb_ptr", {28'd0, ptr_out}, 64'o360600_000006);
      check("tp_ildb_byte", {28'd0, byte_out}, 64'o11);

      // clken stretch
      do_op("ibp_gap", IBP, 36'o000600_000100, 36'd0, 36'd0, 5);
      check("tp_ibp_gap_lat", 64'(last_lat), 64'd7);
      do_op("ldb_gap", LDB, 36'o040600_000000, 36'o123456_701234, 36'd0, 5);

      // Reset during SHIFT cycle 10 of an LDB with P=30
      @(negedge clk);
      op_i = LDB; ptr_i = 36'o360600_000000; word_i = 36'o777777_777777;
      start = 1'b1; clken = 1'b1;
      @(posedge clk);
      @(negedge clk); start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check("rstmid_busy_before", {63'd0, busy}, 64'd1);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      check("rstmid_state", {62'd0, busy, done}, 64'd0);
      check("rstmid_ptr",  {28'd0, ptr_out}, 64'd0);
      check("rstmid_byte", {28'd0, byte_out}, 64'd0);
      check("rstmid_word", {28'd0, word_out}, 64'd0);
      @(negedge clk); rst = 1'b0;
      done_seen = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done || busy) done_seen++;
      end
      check("rstmid_no_done", 64'(done_seen), 64'd0);
      exp_ptr = '0; exp_byte = '0; exp_word = '0;

      // Randomized operations against the model
      for (int i = 0; i < 40; i++) begin
         ro = 2'($urandom_range(0, 3));
         rp = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(37, 63))
                                          : 6'($urandom_range(0, 36));
         rs = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(37, 63))
                                          : 6'($urandom_range(0, 36));
         do_op($sformatf("rnd%0d", i), ro, {rp, rs, 24'($urandom())},
               rnd36(), rnd36(), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
